// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, one bit per clock LSB first, registered results.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sr_q, ans_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;
  logic             s_d, c_d;
  assign s_d = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  // Operands shift right so the current bit is always at position 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      ans_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sr_q    <= {s_d, sr_q[WIDTH-1:1]};
          carry_q <= c_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            ans_q   <= {s_d, sr_q[WIDTH-1:1]};
            cout_q  <= c_d;
            ovf_q   <= carry_q ^ c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          if (start) begin
            a_q     <= x;
            b_q     <= sub ? ~y : y;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign ans  = ans_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors checked against an arithmetic reference model every cycle.
module tb_serial_addsub;
  localparam int W = 8;
  logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0, sub = 1'b0;
  logic [W-1:0] x = '0, y = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] ans;
  int nvec = 0, nerr = 0;
  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .x(x), .y(y),
    .busy(busy), .done(done), .ans(ans), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference result from plain integer arithmetic: {ovf, cout, ans}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = s ? ua - ub : ua + ub;
    sr = s ? sa - sb : sa + sb;
    return {sr > 127 || sr < -128, s ? ua >= ub : ur >= 2**W, ur[W-1:0]};
  endfunction
  int           m_t;
  logic [W-1:0] m_ans, p_ans;
  logic         m_cout, m_ovf, p_cout, p_ovf;
  // m_t counts edges left until the operation leaves its done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0;
      m_ans <= '0;
      m_cout <= 1'b0;
      m_ovf <= 1'b0;
    end else if (m_t <= 1 && start) begin
      m_t <= W + 1;
      {p_ovf, p_cout, p_ans} <= ref_op(x, y, sub);
    end else if (m_t > 0) begin
      m_t <= m_t - 1;
      if (m_t == 2) {m_ovf, m_cout, m_ans} <= {p_ovf, p_cout, p_ans};
    end
  end
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_t > 1));
    chk("done", 32'(done), 32'(m_t == 1));
    chk("ans", 32'(ans), 32'(m_ans));
    chk("cout", 32'(cout), 32'(m_cout));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  end
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                    input logic [W-1:0] ea, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    x = a;
    y = b;
    sub = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(W + 1));
    chk("op_ans", 32'(ans), 32'(ea));
    chk("op_cout", 32'(cout), 32'(ec));
    chk("op_ovf", 32'(ovf), 32'(eo));
  endtask
  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ans", 32'(ans), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    op(8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0);
    op(8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
    op(8'd5, 8'd7, 1'b1, 8'd254, 1'b0, 1'b0);
    op(8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1);
    op(8'd9, 8'd9, 1'b1, 8'd0, 1'b1, 1'b0);
    // Inputs churn and start is re-pulsed while running; only the E0 operands count.
    @(negedge clk);
    x = 8'd3;
    y = 8'd4;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      sub = i[0];
      start = (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("noise_done", 32'(done), 32'd1);
    chk("noise_ans", 32'(ans), 32'd7);
    @(negedge clk);
    chk("noise_once", 32'(done), 32'd0);
    // Start held high: back-to-back operations every W+1 cycles.
    y = 8'd20;
    sub = 1'b0;
    x = 8'd0;
    start = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 28; i++) begin
      @(negedge clk);
      x = W'(i);
      if (done) begin
        cnt++;
        chk("b2b_spacing", 32'(i), 32'(cnt * (W + 1)));
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(cnt), 32'd3);
    repeat (3) @(negedge clk);
    // Reset lands after four bits of an addition.
    x = 8'd100;
    y = 8'd27;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ans", 32'(ans), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_nodone", 32'(cnt), 32'd0);
    op(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    op(8'd0, 8'd1, 1'b1, 8'd255, 1'b0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and result width in bits; the legal range is WIDTH >= 2.
REQ-002 The module SHALL have the following ports, one per line as name, direction, width, meaning:
  - clk  input  1  single clock, rising-edge active.
  - rst_n  input  1  asynchronous active-low reset.
  - start  input  1  operation request, sampled on the rising edge.
  - sub  input  1  mode: 0 computes x+y, 1 computes x-y; captured with start.
  - x  input  WIDTH  first operand; captured with start.
  - y  input  WIDTH  second operand; captured with start.
  - busy  output  1  an operation is in progress.
  - done  output  1  one-cycle pulse; the result outputs are newly valid.
  - ans  output  WIDTH  result.
  - cout  output  1  carry out; for subtraction, 1 means no borrow.
  - ovf  output  1  two's-complement signed overflow.
REQ-003 There SHALL be one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 IDLE or DONE, start=1 at edge E0: capture x into A, capture sub?~y:y into B, set carry to sub, clear the bit counter, go to RUN.
REQ-006 IDLE, start=0: remain in IDLE. DONE, start=0: go to IDLE at the next edge.
REQ-007 RUN SHALL process one bit per edge at E1..E_WIDTH, LSB first.
  - Bit i of the result SHALL be A[i]^B[i]^carry.
  - The new carry SHALL be the full-adder majority of A[i], B[i] and carry.
  - Result bits SHALL shift into an internal register that is separate from ans.
REQ-008 At edge E_WIDTH (counter reaches WIDTH-1), the block SHALL:
  - load ans from the internal result register;
  - set cout to the final carry;
  - set ovf to (carry into MSB) XOR (carry out of MSB);
  - go to DONE.
REQ-009 busy SHALL be 1 exactly while in RUN, which is the WIDTH cycles following E0.
REQ-010 done SHALL be 1 exactly while in DONE, which is the single cycle following E_WIDTH.
REQ-011 Total latency from the start edge to done high SHALL be WIDTH+1 edges.
REQ-012 start=1 while in RUN SHALL be ignored: no restart, no capture, no error.
REQ-013 start=1 during DONE SHALL be accepted per REQ-005.
  - done SHALL fall and busy SHALL rise on the same edge.
  - Back-to-back operations therefore occur every WIDTH+1 cycles.
REQ-014 x, y and sub SHALL be don't-care except at the accepting edge; input changes during RUN SHALL NOT affect the result.
REQ-015 ans, cout and ovf SHALL change only at the E_WIDTH edge or at reset. They SHALL hold their last values through IDLE and through a subsequent RUN.
REQ-016 Arithmetic SHALL be modulo 2^WIDTH, with no saturation.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-018 rst_n=0 SHALL act immediately, independent of clk, and SHALL set:
  - state to IDLE;
  - busy=0, done=0;
  - ans to 0, cout=0, ovf=0;
  - internal carry, counter and shift register to 0.
REQ-019 A reset asserted during RUN SHALL abort the operation: no done pulse and no partial result on ans.
REQ-020 After rst_n deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (WIDTH=8):
  - add 100+27 -> ans=127, cout=0, ovf=0; busy high 8 cycles; done high exactly in the 9th cycle after the start edge.
  - add 200+100 -> ans=44, cout=1, ovf=0; add 127+1 -> ans=128, cout=0, ovf=1.
  - sub 5-7 -> ans=254, cout=0, ovf=0; sub 128-1 -> ans=127, cout=1, ovf=1; sub 9-9 -> ans=0, cout=1, ovf=0.
  - start pulsed during RUN with different x/y, and x/y toggled every cycle during RUN -> result matches the operands captured at E0; done pulses once.
  - start held high continuously -> operations repeat every 9 cycles; done and busy never overlap; ans updates only at each done.
  - rst_n pulsed low mid-RUN (after 4 bits) -> immediate busy=0, ans=0; no done follows; the next start completes correctly.
